// File: rtl/sync_filt_bank_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
package sync_filt_bank_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int FILT_W_DEF      = 4;
    localparam int CH_DEF          = 8;

    // Sticky-flag set term: a filtered edge that its per-channel mask lets through.
    function automatic logic evt_set(
        input logic rise_s,
        input logic fall_s,
        input logic rise_en_s,
        input logic fall_en_s
    );
        return (rise_s & rise_en_s) | (fall_s & fall_en_s);
    endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One conditioner channel: synchroniser chain, stability filter, edge pulses, sticky flag.
module sync_filt_ch
    import sync_filt_bank_pkg::*;
#(
    parameter int STAGES = SYNC_MIN_STAGES,
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              async_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              rise_en,
    input  logic              fall_en,
    input  logic              flag_clr,
    output logic              sync_out,
    output logic              rise,
    output logic              fall,
    output logic              evt_flag
);

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("sync_filt_ch: STAGES must be at least %0d", SYNC_MIN_STAGES);
        end
    endgenerate

    logic [STAGES-1:0] sync_q, sync_d;
    logic              lvl_q, lvl_d;
    logic              lvl_dly_q, lvl_dly_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic              samp_s;
    logic              rise_s;
    logic              fall_s;

    assign samp_s = sync_q[STAGES-1];
    assign rise_s = lvl_q & ~lvl_dly_q;
    assign fall_s = ~lvl_q & lvl_dly_q;

    // Next-state: the chain and the delayed level run every edge; only the filter obeys ena.
    always_comb begin
        sync_d    = {sync_q[STAGES-2:0], async_in};
        lvl_dly_d = lvl_q;
        lvl_d     = lvl_q;
        cnt_d     = cnt_q;
        if (!ena) begin
            lvl_d = lvl_q;
            cnt_d = cnt_q;
        end else if (samp_s == lvl_q) begin
            cnt_d = {FILT_W{1'b0}};
        end else if (cnt_q >= filt_len) begin
            // >= rather than == so a lowered filt_len still flips on the next edge
            lvl_d = samp_s;
            cnt_d = {FILT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(FILT_W-1){1'b0}}, 1'b1};
        end
        flag_d = (flag_q & ~flag_clr) | evt_set(rise_s, fall_s, rise_en, fall_en);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {STAGES{1'b0}};
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
            cnt_q     <= {FILT_W{1'b0}};
            flag_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
        end
    end

    assign sync_out = lvl_q;
    assign rise     = rise_s;
    assign fall     = fall_s;
    assign evt_flag = flag_q;

endmodule

// File: rtl/sync_filt_bank.sv
// Bank of independent input-conditioner channels with a shared filter length and one irq.
module sync_filt_bank
    import sync_filt_bank_pkg::*;
#(
    parameter int CH     = CH_DEF,
    parameter int STAGES = SYNC_MIN_STAGES,
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CH-1:0]     async_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [CH-1:0]     rise_en,
    input  logic [CH-1:0]     fall_en,
    input  logic [CH-1:0]     flag_clr,
    output logic [CH-1:0]     sync_out,
    output logic [CH-1:0]     rise,
    output logic [CH-1:0]     fall,
    output logic [CH-1:0]     evt_flag,
    output logic              irq
);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            sync_filt_ch #(
                .STAGES (STAGES),
                .FILT_W (FILT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .ena      (ena),
                .async_in (async_in[i]),
                .filt_len (filt_len),
                .rise_en  (rise_en[i]),
                .fall_en  (fall_en[i]),
                .flag_clr (flag_clr[i]),
                .sync_out (sync_out[i]),
                .rise     (rise[i]),
                .fall     (fall[i]),
                .evt_flag (evt_flag[i])
            );
        end
    endgenerate

    // Reduction of flag registers only, so irq cannot glitch.
    assign irq = |evt_flag;

endmodule

// File: tb/tb_sync_filt_bank.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with a cycle number,
// a monitor pops and compares them on the falling edge of that cycle.
module tb_sync_filt_bank;

    localparam int CH     = 8;
    localparam int STAGES = 2;
    localparam int FILT_W = 4;

    localparam int SEL_LVL  = 0;
    localparam int SEL_RISE = 1;
    localparam int SEL_FALL = 2;
    localparam int SEL_EVT  = 3;
    localparam int SEL_IRQ  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [CH-1:0]     async_in;
    logic [FILT_W-1:0] filt_len;
    logic [CH-1:0]     rise_en;
    logic [CH-1:0]     fall_en;
    logic [CH-1:0]     flag_clr;
    logic [CH-1:0]     sync_out;
    logic [CH-1:0]     rise;
    logic [CH-1:0]     fall;
    logic [CH-1:0]     evt_flag;
    logic              irq;

    sync_filt_bank #(.CH(CH), .STAGES(STAGES), .FILT_W(FILT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .async_in (async_in),
        .filt_len (filt_len),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .flag_clr (flag_clr),
        .sync_out (sync_out),
        .rise     (rise),
        .fall     (fall),
        .evt_flag (evt_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          sel;
        logic [7:0]  mask;
        logic [7:0]  val;
        string       name;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] act;

    task automatic push_exp(input int off, input int sel, input logic [7:0] mask,
                            input logic [7:0] val, input string name);
        exp_t e;
        e.at   = cyc + off;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            SEL_LVL:  return sync_out;
            SEL_RISE: return rise;
            SEL_FALL: return fall;
            SEL_EVT:  return evt_flag;
            SEL_IRQ:  return {7'b0, irq};
            default:  return 8'h00;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    checks++;
                    act = pick(sb[i].sel) & sb[i].mask;
                    if (act !== (sb[i].val & sb[i].mask)) begin
                        errors++;
                        $display("FAIL %s: cycle %0d got %02h want %02h (mask %02h)",
                                 sb[i].name, cyc, act, sb[i].val & sb[i].mask, sb[i].mask);
                    end
                    sb.delete(i);
                end else if (sb[i].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].at);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        async_in = 8'hFF;
        filt_len = 4'd0;
        rise_en  = 8'h00;
        fall_en  = 8'h00;
        flag_clr = 8'h00;

        // Reset with inputs high, then bypass-mode release.
        step(3);
        push_exp(0, SEL_LVL,  8'hFF, 8'h00, "rst_lvl");
        push_exp(0, SEL_RISE, 8'hFF, 8'h00, "rst_rise");
        push_exp(0, SEL_EVT,  8'hFF, 8'h00, "rst_evt");
        push_exp(0, SEL_IRQ,  8'h01, 8'h00, "rst_irq");
        rst_n = 1'b1;
        push_exp(2, SEL_LVL,  8'hFF, 8'h00, "rel_lvl_e2");
        push_exp(3, SEL_LVL,  8'hFF, 8'hFF, "rel_lvl_e3");
        push_exp(2, SEL_RISE, 8'hFF, 8'h00, "rel_rise_e2");
        push_exp(3, SEL_RISE, 8'hFF, 8'hFF, "rel_rise_e3");
        push_exp(4, SEL_RISE, 8'hFF, 8'h00, "rel_rise_e4");
        step(6);
        async_in = 8'h00;
        push_exp(3, SEL_FALL, 8'hFF, 8'hFF, "bypass_fall");
        step(5);

        // Latency with filt_len = 3 on ch0.
        filt_len = 4'd3;
        async_in = 8'h01;
        push_exp(5, SEL_LVL,  8'h01, 8'h00, "lat_lvl_e5");
        push_exp(6, SEL_LVL,  8'h01, 8'h01, "lat_lvl_e6");
        push_exp(5, SEL_RISE, 8'h01, 8'h00, "lat_rise_e5");
        push_exp(6, SEL_RISE, 8'h01, 8'h01, "lat_rise_e6");
        push_exp(7, SEL_RISE, 8'h01, 8'h00, "lat_rise_e7");
        push_exp(6, SEL_FALL, 8'h01, 8'h00, "lat_fall_e6");
        push_exp(7, SEL_FALL, 8'h01, 8'h00, "lat_fall_e7");
        step(3);

        // Glitch of 3 cycles on ch2 is rejected.
        async_in = 8'h05;
        for (int k = 1; k <= 10; k++) begin
            push_exp(k, SEL_LVL,  8'h04, 8'h00, "glitch_lvl");
            push_exp(k, SEL_RISE, 8'h04, 8'h00, "glitch_rise");
        end
        step(3);
        async_in = 8'h01;
        step(8);

        // A 4-cycle pulse on ch2 gets through.
        async_in = 8'h05;
        push_exp(5, SEL_LVL,  8'h04, 8'h00, "pulse4_lvl_e5");
        push_exp(6, SEL_LVL,  8'h04, 8'h04, "pulse4_lvl_e6");
        push_exp(6, SEL_RISE, 8'h04, 8'h04, "pulse4_rise");
        step(4);
        async_in = 8'h01;
        step(10);

        // Flags and masks in bypass mode.
        filt_len = 4'd0;
        async_in = 8'h00;
        step(5);
        push_exp(0, SEL_EVT, 8'hFF, 8'h00, "flags_idle");
        rise_en  = 8'h01;
        fall_en  = 8'h02;
        async_in = 8'h03;
        push_exp(3, SEL_RISE, 8'h03, 8'h03, "flag_rise_pulse");
        push_exp(4, SEL_EVT,  8'hFF, 8'h01, "flag_rise_only");
        push_exp(4, SEL_IRQ,  8'h01, 8'h01, "irq_set");
        step(4);
        async_in = 8'h00;
        push_exp(3, SEL_FALL, 8'h03, 8'h03, "flag_fall_pulse");
        push_exp(4, SEL_EVT,  8'hFF, 8'h03, "flag_both");
        step(4);
        async_in = 8'h01;
        step(3);
        flag_clr = 8'h01;
        step(1);
        flag_clr = 8'h00;
        push_exp(0, SEL_EVT, 8'hFF, 8'h03, "clr_vs_set");
        push_exp(1, SEL_EVT, 8'hFF, 8'h03, "clr_vs_set_hold");
        step(3);
        flag_clr = 8'h01;
        push_exp(1, SEL_EVT, 8'hFF, 8'h02, "clr_ch0");
        push_exp(1, SEL_IRQ, 8'h01, 8'h01, "irq_ch1");
        step(1);
        flag_clr = 8'h02;
        push_exp(1, SEL_EVT, 8'hFF, 8'h00, "clr_all");
        push_exp(1, SEL_IRQ, 8'h01, 8'h00, "irq_clr");
        step(1);
        flag_clr = 8'h00;
        step(2);

        // Enable freeze while ch3 toggles.
        filt_len = 4'd2;
        ena      = 1'b0;
        async_in = 8'h09;
        for (int k = 1; k <= 10; k++) begin
            push_exp(k, SEL_LVL,  8'h08, 8'h00, "frz_lvl");
            push_exp(k, SEL_RISE, 8'h08, 8'h00, "frz_rise");
            push_exp(k, SEL_FALL, 8'h08, 8'h00, "frz_fall");
        end
        step(3);
        async_in = 8'h01;
        step(3);
        async_in = 8'h09;
        step(4);
        ena = 1'b1;
        push_exp(2, SEL_LVL,  8'h08, 8'h00, "en_lvl_e2");
        push_exp(3, SEL_LVL,  8'h08, 8'h08, "en_lvl_e3");
        push_exp(3, SEL_RISE, 8'h08, 8'h08, "en_rise");
        step(5);

        // Reset while ch5's counter sits at 5 of 7.
        filt_len = 4'd7;
        async_in = 8'h29;
        step(7);
        rst_n = 1'b0;
        push_exp(0, SEL_LVL,  8'hFF, 8'h00, "midrst_lvl");
        push_exp(0, SEL_RISE, 8'hFF, 8'h00, "midrst_rise");
        push_exp(0, SEL_EVT,  8'hFF, 8'h00, "midrst_evt");
        push_exp(0, SEL_IRQ,  8'h01, 8'h00, "midrst_irq");
        step(2);
        rst_n = 1'b1;
        push_exp(9,  SEL_LVL,  8'hFF, 8'h00, "post_rst_e9");
        push_exp(10, SEL_LVL,  8'hFF, 8'h29, "post_rst_e10");
        push_exp(10, SEL_RISE, 8'hFF, 8'h29, "post_rst_rise");
        step(12);

        for (int k = 0; k < 50 && sb.size() > 0; k++) begin
            step(1);
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
